// File: rtl/thor2024_agen_sched.sv
`default_nettype none
// ============================================================================
// Module   : thor2024_agen_sched
// Brief    : Round-robin address-generation scheduler with a two-stage
//            base+disp+(index<<scale) pipeline feeding writeback or memory.
// Revision : 1.0
// ============================================================================
module thor2024_agen_sched #(
    parameter int NREQ = 4,
    parameter int AWID = 64
) (
    input  logic                   rst,
    input  logic                   clk,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_grant,
    input  logic [NREQ-1:0]        req_lda,
    input  logic [NREQ*AWID-1:0]   req_base,
    input  logic [NREQ*AWID-1:0]   req_index,
    input  logic [NREQ*2-1:0]      req_scale,
    input  logic [NREQ*AWID-1:0]   req_disp,
    input  logic [NREQ*5-1:0]      req_tag,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic                   mq_valid,
    input  logic                   mq_ready,
    output logic [AWID-1:0]        out_adr,
    output logic [4:0]             out_tag,
    output logic [31:0]            lda_count
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_RST = c_PTR_W'(NREQ - 1);

    // Stage 1: partial sums
    logic                r_s1_valid;
    logic                r_s1_lda;
    logic [4:0]          r_s1_tag;
    logic [AWID-1:0]     r_s1_bd;
    logic [AWID-1:0]     r_s1_is;

    // Stage 2: final address
    logic                r_s2_valid;
    logic                r_s2_lda;
    logic [4:0]          r_s2_tag;
    logic [AWID-1:0]     r_s2_adr;

    logic [c_PTR_W-1:0]  r_rr_ptr;
    logic [31:0]         r_lda_count;

    logic                w_s2_adv;
    logic                w_s2_open;
    logic                w_s1_free;
    logic                w_hit;
    logic                w_gnt_any;
    logic [c_PTR_W-1:0]  w_gnt_idx;
    logic [NREQ-1:0]     w_grant;

    logic [AWID-1:0]     w_base;
    logic [AWID-1:0]     w_index;
    logic [AWID-1:0]     w_disp;
    logic [1:0]          w_scale;
    logic [4:0]          w_tag;
    logic                w_lda;

    assign w_s2_adv  = r_s2_valid & (r_s2_lda ? wb_ready : mq_ready);
    assign w_s2_open = ~r_s2_valid | w_s2_adv;
    assign w_s1_free = ~r_s1_valid | w_s2_open;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        w_hit     = 1'b0;
        w_gnt_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_hit && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_hit     = 1'b1;
                w_gnt_idx = c_PTR_W'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    assign w_gnt_any = w_hit & w_s1_free & ~flush & ~rst;

    always_comb begin
        w_grant = '0;
        if (w_gnt_any) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    assign req_grant = w_grant;

    assign w_base  = req_base [int'(w_gnt_idx)*AWID +: AWID];
    assign w_index = req_index[int'(w_gnt_idx)*AWID +: AWID];
    assign w_disp  = req_disp [int'(w_gnt_idx)*AWID +: AWID];
    assign w_scale = req_scale[int'(w_gnt_idx)*2 +: 2];
    assign w_tag   = req_tag  [int'(w_gnt_idx)*5 +: 5];
    assign w_lda   = req_lda  [w_gnt_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_lda   <= 1'b0;
            r_s1_tag   <= '0;
            r_s1_bd    <= '0;
            r_s1_is    <= '0;
            r_rr_ptr   <= c_PTR_RST;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_free) begin
                r_s1_valid <= w_gnt_any;
            end
            if (w_gnt_any) begin
                r_s1_lda <= w_lda;
                r_s1_tag <= w_tag;
                r_s1_bd  <= w_base + w_disp;
                r_s1_is  <= w_index << w_scale;
                r_rr_ptr <= w_gnt_idx;
            end
        end
    end

    // S2 holds its contents whenever its sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_lda   <= 1'b0;
            r_s2_tag   <= '0;
            r_s2_adr   <= '0;
        end else begin
            if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_open) begin
                r_s2_valid <= r_s1_valid;
            end
            if (!flush && w_s2_open && r_s1_valid) begin
                r_s2_lda <= r_s1_lda;
                r_s2_tag <= r_s1_tag;
                r_s2_adr <= r_s1_bd + r_s1_is;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lda_count <= '0;
        end else if (wb_valid && wb_ready) begin
            r_lda_count <= r_lda_count + 32'd1;
        end
    end

    assign wb_valid  = r_s2_valid &  r_s2_lda;
    assign mq_valid  = r_s2_valid & ~r_s2_lda;
    assign out_adr   = r_s2_adr;
    assign out_tag   = r_s2_tag;
    assign lda_count = r_lda_count;

endmodule
`default_nettype wire

// File: tb/tb_thor2024_agen_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_thor2024_agen_sched
// Brief    : Self-checking bench: vector table, scoreboard, corner sequences.
// Revision : 1.0
// ============================================================================
module tb_thor2024_agen_sched;

    localparam int NREQ = 4;
    localparam int AWID = 64;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_grant;
    logic [NREQ-1:0]      req_lda;
    logic [NREQ*AWID-1:0] req_base;
    logic [NREQ*AWID-1:0] req_index;
    logic [NREQ*2-1:0]    req_scale;
    logic [NREQ*AWID-1:0] req_disp;
    logic [NREQ*5-1:0]    req_tag;
    logic                 wb_valid;
    logic                 wb_ready;
    logic                 mq_valid;
    logic                 mq_ready;
    logic [AWID-1:0]      out_adr;
    logic [4:0]           out_tag;
    logic [31:0]          lda_count;

    thor2024_agen_sched #(.NREQ(NREQ), .AWID(AWID)) dut (
        .rst(rst), .clk(clk), .flush(flush),
        .req_valid(req_valid), .req_grant(req_grant), .req_lda(req_lda),
        .req_base(req_base), .req_index(req_index), .req_scale(req_scale),
        .req_disp(req_disp), .req_tag(req_tag),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .mq_valid(mq_valid), .mq_ready(mq_ready),
        .out_adr(out_adr), .out_tag(out_tag), .lda_count(lda_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          r;
        logic        lda;
        logic [63:0] base;
        logic [63:0] index;
        logic [1:0]  sc;
        logic [63:0] disp;
        logic [4:0]  tag;
        logic [63:0] exp_adr;
        logic [31:0] exp_cnt;
    } vec_t;

    typedef struct packed {
        logic [63:0] adr;
        logic [4:0]  tag;
        logic        lda;
    } sb_t;

    vec_t        tbl [5];
    sb_t         sb [$];
    logic [63:0] exp_adr [NREQ];
    logic [4:0]  exp_tag [NREQ];
    logic        exp_lda [NREQ];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] saved_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] agen(input logic [63:0] b, input logic [63:0] i,
                                         input logic [1:0] s, input logic [63:0] d);
        return b + d + (i << s);
    endfunction

    task automatic set_req(input int r, input logic lda, input logic [63:0] b,
                           input logic [63:0] i, input logic [1:0] s, input logic [63:0] d,
                           input logic [4:0] t, input logic [63:0] e);
        req_lda[r]            = lda;
        req_base[r*64 +: 64]  = b;
        req_index[r*64 +: 64] = i;
        req_scale[r*2 +: 2]   = s;
        req_disp[r*64 +: 64]  = d;
        req_tag[r*5 +: 5]     = t;
        exp_adr[r] = e;
        exp_tag[r] = t;
        exp_lda[r] = lda;
    endtask

    task automatic set_stream(input logic [NREQ-1:0] ldamask);
        for (int r = 0; r < NREQ; r++) begin
            logic [63:0] b, i, d;
            logic [1:0]  s;
            b = 64'h0000_0000_4000_0000 + 64'(r) * 64'h100;
            i = 64'(r + 3);
            s = 2'(r);
            d = 64'h0 - 64'(4 * r);
            set_req(r, ldamask[r], b, i, s, d, 5'(10 + r), agen(b, i, s, d));
        end
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: push on grant, pop on output handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (wb_valid || mq_valid) check("sinks_exclusive", 64'(wb_valid & mq_valid), 64'd0);
            if ((wb_valid && wb_ready) || (mq_valid && mq_ready)) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got output adr %h expected none", out_adr);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("sb_adr", out_adr, e.adr);
                    check("sb_tag", 64'(out_tag), 64'(e.tag));
                    check("sb_sink_lda", 64'(wb_valid), 64'(e.lda));
                end
            end
            if (flush) begin
                sb.delete();
            end else if (req_grant != '0) begin
                check("grant_onehot", 64'($onehot(req_grant)), 64'd1);
                check("grant_valid", 64'(req_grant & ~req_valid), 64'd0);
                for (int r = 0; r < NREQ; r++) begin
                    if (req_grant[r]) sb.push_back('{adr: exp_adr[r], tag: exp_tag[r], lda: exp_lda[r]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 1'b1, 64'h1000, 64'h10, 2'd3, 64'hFFFF_FFFF_FFFF_FFF8, 5'd5,
                   64'h1078, 32'd1};
        tbl[1] = '{1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 2'd0, 64'h10, 5'd9,
                   64'h8, 32'd1};
        tbl[2] = '{2, 1'b0, 64'h2000, 64'h3, 2'd2, 64'h4, 5'd17,
                   64'h2010, 32'd1};
        tbl[3] = '{3, 1'b1, 64'h0, 64'h8000_0000_0000_0001, 2'd1, 64'h0, 5'd31,
                   64'h2, 32'd2};
        tbl[4] = '{0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h10, 2'd0, 64'h10, 5'd0,
                   64'h1234_5678_9ABC_DF10, 32'd2};

        rst = 1'b1; flush = 1'b0; wb_ready = 1'b1; mq_ready = 1'b1;
        req_valid = '1; req_lda = '0; req_base = '0; req_index = '0;
        req_scale = '0; req_disp = '0; req_tag = '0;
        for (int r = 0; r < NREQ; r++) begin
            exp_adr[r] = '0; exp_tag[r] = '0; exp_lda[r] = 1'b0;
        end

        // Reset state with requesters asserted
        @(posedge clk);
        @(negedge clk);
        check("rst_grant", 64'(req_grant), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_mq_valid", 64'(mq_valid), 64'd0);
        check("rst_lda_count", 64'(lda_count), 64'd0);
        check("rst_out_adr", out_adr, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;

        // Single-request vectors: grant, two-cycle latency, address, count
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #1;
            set_req(tbl[v].r, tbl[v].lda, tbl[v].base, tbl[v].index, tbl[v].sc,
                    tbl[v].disp, tbl[v].tag, tbl[v].exp_adr);
            req_valid = NREQ'(1) << tbl[v].r;
            @(negedge clk);
            check("vec_grant", 64'(req_grant), 64'(NREQ'(1) << tbl[v].r));
            @(posedge clk); #1;
            req_valid = '0;
            @(posedge clk);
            @(negedge clk);
            check("vec_wb_valid", 64'(wb_valid), 64'(tbl[v].lda));
            check("vec_mq_valid", 64'(mq_valid), 64'(!tbl[v].lda));
            @(posedge clk); #1;
            check("vec_lda_count", 64'(lda_count), 64'(tbl[v].exp_cnt));
        end

        // Round-robin order from reset: 0,1,2,3,0
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_stream(4'b0110);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_grant", 64'(req_grant), 64'(NREQ'(1) << (k % NREQ)));
            @(posedge clk);
        end
        #1;
        req_valid = '0;
        drain();

        // Memory-queue backpressure: S2 held, S1 fills, grants stop
        @(posedge clk); #1;
        set_stream(4'b0000);
        mq_ready = 1'b0;
        req_valid = '1;
        @(negedge clk);
        check("bp_grant1", 64'(req_grant), 64'b0010);
        @(posedge clk);
        @(negedge clk);
        check("bp_grant2", 64'(req_grant), 64'b0100);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_no_grant", 64'(req_grant), 64'd0);
            check("bp_mq_valid", 64'(mq_valid), 64'd1);
            check("bp_adr_stable", out_adr, exp_adr[1]);
            @(posedge clk);
        end
        #1;
        mq_ready = 1'b1;
        req_valid = '0;
        drain();

        // Flush with both stages full behind a stalled writeback
        @(posedge clk); #1;
        set_stream(4'b1111);
        wb_ready = 1'b0;
        req_valid = 4'b0011;
        @(negedge clk);
        check("fl_grant1", 64'(req_grant), 64'b0001);
        @(posedge clk);
        @(negedge clk);
        check("fl_grant2", 64'(req_grant), 64'b0010);
        @(posedge clk);
        @(negedge clk);
        check("fl_stalled", 64'(wb_valid), 64'd1);
        saved_cnt = lda_count;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("fl_no_grant_full", 64'(req_grant), 64'd0);
        @(posedge clk); #1;
        check("fl_wb_valid", 64'(wb_valid), 64'd0);
        check("fl_mq_valid", 64'(mq_valid), 64'd0);
        check("fl_lda_count", 64'(lda_count), 64'(saved_cnt));
        @(negedge clk);
        check("fl_no_grant_empty", 64'(req_grant), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        wb_ready = 1'b1;
        @(negedge clk);
        check("fl_ptr_kept", 64'(req_grant), 64'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // Asynchronous reset mid-stream, between clock edges
        @(posedge clk); #1;
        set_stream(4'b0101);
        req_valid = '1;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("ar_wb_valid", 64'(wb_valid), 64'd0);
        check("ar_mq_valid", 64'(mq_valid), 64'd0);
        check("ar_grant", 64'(req_grant), 64'd0);
        check("ar_lda_count", 64'(lda_count), 64'd0);
        check("ar_out_adr", out_adr, 64'd0);
        check("ar_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ar_first_grant", 64'(req_grant), 64'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
